// File: rtl/leg_pkg.sv
// Shared definitions for the LEG branch/PC unit: opcode ranges, PC step and FSM states.
package leg_pkg;

  localparam logic [5:0] COND_FIRST = 6'h20;
  localparam logic [5:0] COND_LAST  = 6'h29;
  localparam logic [5:0] OP_CALL    = 6'h14;
  localparam logic [5:0] OP_RET     = 6'h15;
  localparam logic [7:0] PC_STEP    = 8'd4;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  function automatic logic is_cond(input logic [5:0] op);
    return (op >= COND_FIRST) && (op <= COND_LAST);
  endfunction

endpackage

// File: rtl/leg_ret_stack.sv
// LIFO of return addresses for CALL/RET; push when full and pop when empty are ignored.
module leg_ret_stack
  import leg_pkg::*;
#(
  parameter int UUID  = 0,
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int PW = $clog2(DEPTH);

  logic [7:0] r_mem [DEPTH];
  logic [PW:0] r_sp;
  logic [PW-1:0] w_top;

  assign full  = (r_sp == (PW+1)'(DEPTH));
  assign empty = (r_sp == '0);
  assign w_top = r_sp[PW-1:0] - PW'(1);
  assign dout  = r_mem[w_top];

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      r_sp <= '0;
    end else if (push && !full) begin
      r_sp <= r_sp + 1'b1;
    end else if (pop && !empty) begin
      r_sp <= r_sp - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the pointer alone defines which entries are valid.
    if (push && !full) begin
      r_mem[r_sp[PW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/leg_branch_pc.sv
// Program counter with conditional branches and a one-cycle FLUSH after every redirect.
// Define LEG_CALL_STACK_EN to add CALL/RET backed by leg_ret_stack.
module leg_branch_pc
  import leg_pkg::*;
#(
  parameter int UUID        = 0,
  parameter     NAME        = "",
  parameter int STACK_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] opcode,
  input  logic       cond_true,
  input  logic [7:0] target,
  output logic [7:0] pc,
  output logic       taken,
  output logic       flush,
  output logic       stk_ovf,
  output logic       stk_unf
);

  state_e     r_state, w_next_state;
  logic [7:0] r_pc, w_next_pc, w_pc_inc;
  logic       r_taken, w_next_taken;
  logic [5:0] w_op;

`ifdef LEG_CALL_STACK_EN
  logic       r_ovf, r_unf;
  logic       w_push, w_pop, w_set_ovf, w_set_unf;
  logic       w_stk_full, w_stk_empty;
  logic [7:0] w_stk_dout;

  leg_ret_stack #(
    .UUID  (UUID ^ 1),
    .DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_pc_inc),
    .dout  (w_stk_dout),
    .full  (w_stk_full),
    .empty (w_stk_empty)
  );
`endif

  assign w_op     = opcode[5:0];
  assign w_pc_inc = r_pc + PC_STEP;

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_next_taken = 1'b0;
`ifdef LEG_CALL_STACK_EN
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_set_ovf = 1'b0;
    w_set_unf = 1'b0;
`endif
    case (r_state)
      ST_RUN: begin
        if (en) begin
          if (is_cond(w_op)) begin
            if (cond_true) begin
              w_next_pc    = target;
              w_next_taken = 1'b1;
              w_next_state = ST_FLUSH;
            end else begin
              w_next_pc = w_pc_inc;
            end
          end
`ifdef LEG_CALL_STACK_EN
          else if (w_op == OP_CALL) begin
            // A full stack loses the return address but the jump still happens.
            w_push       = !w_stk_full;
            w_set_ovf    = w_stk_full;
            w_next_pc    = target;
            w_next_taken = 1'b1;
            w_next_state = ST_FLUSH;
          end else if (w_op == OP_RET) begin
            if (w_stk_empty) begin
              w_set_unf = 1'b1;
              w_next_pc = w_pc_inc;
            end else begin
              w_pop        = 1'b1;
              w_next_pc    = w_stk_dout;
              w_next_taken = 1'b1;
              w_next_state = ST_FLUSH;
            end
          end
`endif
          else begin
            w_next_pc = w_pc_inc;
          end
        end
      end
      ST_FLUSH: w_next_state = ST_RUN;
      default:  w_next_state = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_pc    <= 8'h00;
      r_taken <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
      r_taken <= w_next_taken;
    end
  end

`ifdef LEG_CALL_STACK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= r_ovf | w_set_ovf;
      r_unf <= r_unf | w_set_unf;
    end
  end

  assign stk_ovf = r_ovf;
  assign stk_unf = r_unf;
`else
  assign stk_ovf = 1'b0;
  assign stk_unf = 1'b0;
`endif

  assign pc    = r_pc;
  assign taken = r_taken;
  assign flush = (r_state == ST_FLUSH);

endmodule
